// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and access-legality helper for the MEM-stage load/store unit.
package lsu_pkg;

  localparam int LSU_WIDTH      = 32;
  localparam int LSU_ADDR_WIDTH = 32;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } lsu_state_t;

  // Illegal funct3 for the access direction, or an offset the access size cannot use.
  function automatic logic access_bad(input logic is_store, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic bad_f3;
    logic bad_align;
    if (is_store) begin
      bad_f3 = (f3 >= 3'd3);
    end else begin
      bad_f3 = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    end
    case (f3[1:0])
      2'b01:   bad_align = off[0];
      2'b10:   bad_align = (off != 2'b00);
      default: bad_align = 1'b0;
    endcase
    return bad_f3 | bad_align;
  endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Data-memory valid/ready port between the load/store unit (master) and memory (slave).
interface lsu_mem_stage_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic [3:0]            mem_wstrb;
  logic                  mem_ready;
  logic [WIDTH-1:0]      mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/lsu_mem_stage_load_extend.sv
// Picks the addressed byte/half of a read word and sign- or zero-extends it per funct3.
module load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] ext
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select followed by extension.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    ext    = rdata;
    case (addr)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
    case (funct3)
      F3_B:    ext = {{24{byte_s[7]}}, byte_s};
      F3_BU:   ext = {24'h000000, byte_s};
      F3_H:    ext = {{16{half_s[15]}}, half_s};
      F3_HU:   ext = {16'h0000, half_s};
      F3_W:    ext = rdata;
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: issues one memory transaction per access, stalls until ready,
// and registers the extended load result for writeback.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int WIDTH      = LSU_WIDTH,
  parameter int ADDR_WIDTH = LSU_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            Funct3M,
  input  logic [ADDR_WIDTH-1:0] ALUResultM,
  input  logic [WIDTH-1:0]      WriteDataM,
  input  logic                  FlushM,
  output logic                  StallM,
  output logic                  ExcM,
  output logic [WIDTH-1:0]      ReadDataW,
  lsu_mem_stage_if.master       mem
);

  lsu_state_t            state_r;
  lsu_state_t            state_nxt_s;
  logic                  acc_s;
  logic                  bad_s;
  logic                  start_s;
  logic [3:0]            wstrb_s;
  logic [WIDTH-1:0]      wdata_s;
  logic [WIDTH-1:0]      ext_s;

  logic                  req_r;
  logic                  we_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [WIDTH-1:0]      wdata_r;
  logic [3:0]            wstrb_r;
  logic [2:0]            f3_r;
  logic [1:0]            off_r;
  logic                  discard_r;
  logic [WIDTH-1:0]      rdw_r;

  assign acc_s   = (MemReadM | MemWriteM) & ~FlushM;
  assign bad_s   = access_bad(MemWriteM, Funct3M, ALUResultM[1:0]);
  assign start_s = (state_r == IDLE) && (state_nxt_s == BUSY);

  // Store lane formatting from the live address; loads carry no strobes.
  always_comb begin
    wstrb_s = 4'h0;
    wdata_s = WriteDataM;
    case (Funct3M[1:0])
      2'b00: begin
        wstrb_s = 4'b0001 << ALUResultM[1:0];
        wdata_s = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        wstrb_s = 4'b0011 << {ALUResultM[1], 1'b0};
        wdata_s = {2{WriteDataM[15:0]}};
      end
      default: begin
        wstrb_s = 4'hF;
        wdata_s = WriteDataM;
      end
    endcase
    if (!MemWriteM) begin
      wstrb_s = 4'h0;
    end else begin
      wstrb_s = wstrb_s;
    end
  end

  // Next state, stall and exception decode.
  always_comb begin
    state_nxt_s = state_r;
    StallM      = 1'b0;
    ExcM        = 1'b0;
    case (state_r)
      IDLE: begin
        ExcM = acc_s & bad_s;
        if (acc_s && !bad_s) begin
          StallM      = 1'b1;
          state_nxt_s = BUSY;
        end else begin
          StallM      = 1'b0;
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        StallM = ~mem.mem_ready;
        if (mem.mem_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request fields are captured once so they stay stable while the memory waits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_r   <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      wstrb_r <= 4'h0;
      f3_r    <= 3'd0;
      off_r   <= 2'd0;
    end else if (start_s) begin
      req_r   <= 1'b1;
      we_r    <= MemWriteM;
      addr_r  <= {ALUResultM[ADDR_WIDTH-1:2], 2'b00};
      wdata_r <= wdata_s;
      wstrb_r <= wstrb_s;
      f3_r    <= Funct3M;
      off_r   <= ALUResultM[1:0];
    end else if ((state_r == BUSY) && mem.mem_ready) begin
      req_r   <= 1'b0;
    end else begin
      req_r   <= req_r;
    end
  end

  // A flush while busy cannot abort the bus cycle, so it only suppresses the writeback.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      discard_r <= 1'b0;
    end else if ((state_r == BUSY) && !mem.mem_ready) begin
      discard_r <= discard_r | FlushM;
    end else begin
      discard_r <= 1'b0;
    end
  end

  load_extend u_load_extend (
    .funct3 (f3_r),
    .addr   (off_r),
    .rdata  (mem.mem_rdata),
    .ext    (ext_s)
  );

  // Load result capture on completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdw_r <= '0;
    end else if ((state_r == BUSY) && mem.mem_ready && !we_r && !discard_r && !FlushM) begin
      rdw_r <= ext_s;
    end else begin
      rdw_r <= rdw_r;
    end
  end

  assign ReadDataW     = rdw_r;
  assign mem.mem_req   = req_r;
  assign mem.mem_we    = we_r;
  assign mem.mem_addr  = addr_r;
  assign mem.mem_wdata = wdata_r;
  assign mem.mem_wstrb = wstrb_r;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed vector table, reset-in-flight sequence,
// and randomized instructions checked against a transaction-level reference model.
module tb_lsu_mem_stage;
  import lsu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        MemReadM;
  logic        MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        FlushM;
  logic        StallM;
  logic        ExcM;
  logic [31:0] ReadDataW;

  int passed;
  int total;

  lsu_mem_stage_if #(.WIDTH(32), .ADDR_WIDTH(32)) mbus ();

  lsu_mem_stage #(.WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .FlushM     (FlushM),
    .StallM     (StallM),
    .ExcM       (ExcM),
    .ReadDataW  (ReadDataW),
    .mem        (mbus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          waits;
    logic [31:0] rdata;
    int          flush_k;
    logic        flush_idle;
    logic        e_exc;
    logic        e_we;
    logic [31:0] e_addr;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
    logic [31:0] e_rdw;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (ok) begin
      passed++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One MEM-stage instruction as the pipeline and memory would drive it.
  task automatic run_instr(input vec_t v, input string tag);
    logic acc;
    MemReadM   = v.rd;
    MemWriteM  = v.wr;
    Funct3M    = v.f3;
    ALUResultM = v.addr;
    WriteDataM = v.wd;
    FlushM     = v.flush_idle;
    mbus.mem_ready = 1'b0;
    mbus.mem_rdata = $urandom;
    #1;
    acc = (v.rd | v.wr) & ~v.flush_idle;
    chk(ExcM == v.e_exc, {tag, " exc"}, {31'd0, ExcM}, {31'd0, v.e_exc});
    chk(StallM == (acc & ~v.e_exc), {tag, " stall_idle"}, {31'd0, StallM}, {31'd0, acc & ~v.e_exc});
    chk(mbus.mem_req == 1'b0, {tag, " req_idle"}, {31'd0, mbus.mem_req}, 32'd0);
    cyc();
    FlushM = 1'b0;
    if (acc && !v.e_exc) begin
      for (int k = 0; k <= v.waits; k++) begin
        FlushM         = (k == v.flush_k);
        mbus.mem_ready = (k == v.waits);
        mbus.mem_rdata = (k == v.waits) ? v.rdata : $urandom;
        #1;
        chk(mbus.mem_req == 1'b1, {tag, " req_busy"}, {31'd0, mbus.mem_req}, 32'd1);
        chk(mbus.mem_addr == v.e_addr, {tag, " addr"}, mbus.mem_addr, v.e_addr);
        chk(mbus.mem_we == v.e_we, {tag, " we"}, {31'd0, mbus.mem_we}, {31'd0, v.e_we});
        chk(mbus.mem_wstrb == v.e_wstrb, {tag, " wstrb"}, {28'd0, mbus.mem_wstrb}, {28'd0, v.e_wstrb});
        if (v.e_we) begin
          chk(mbus.mem_wdata == v.e_wdata, {tag, " wdata"}, mbus.mem_wdata, v.e_wdata);
        end
        chk(StallM == (k != v.waits), {tag, " stall_busy"}, {31'd0, StallM}, {31'd0, k != v.waits});
        cyc();
      end
      mbus.mem_ready = 1'b0;
      FlushM         = 1'b0;
    end
    chk(ReadDataW == v.e_rdw, {tag, " rdw"}, ReadDataW, v.e_rdw);
  endtask

  // Reference model: what an instruction should do, from the ISA-level access rules.
  function automatic vec_t model(input vec_t v, input logic [31:0] prev_rdw);
    vec_t   r;
    int     size;
    int     off;
    logic   bad;
    logic   acc;
    logic [31:0] b;
    logic [31:0] h;
    r    = v;
    size = int'(v.f3) % 4;
    off  = int'(v.addr % 32'd4);
    if (v.wr) bad = (v.f3 >= 3'd3);
    else      bad = (v.f3 == 3'd3) || (v.f3 >= 3'd6);
    if (size == 1 && (off % 2) != 0) bad = 1'b1;
    if (size == 2 && off != 0)       bad = 1'b1;
    acc       = (v.rd | v.wr) & ~v.flush_idle;
    r.e_exc   = acc & bad;
    r.e_we    = v.wr;
    r.e_addr  = v.addr - off;
    r.e_wstrb = 4'h0;
    r.e_wdata = v.wd;
    if (v.wr) begin
      if (size == 0) begin
        r.e_wstrb = 4'(1 << off);
        r.e_wdata = (v.wd & 32'hFF) * 32'h01010101;
      end else if (size == 1) begin
        r.e_wstrb = (off < 2) ? 4'h3 : 4'hC;
        r.e_wdata = (v.wd & 32'hFFFF) * 32'h00010001;
      end else begin
        r.e_wstrb = 4'hF;
      end
    end
    r.e_rdw = prev_rdw;
    if (acc && !bad && v.rd && v.flush_k < 0) begin
      b = (v.rdata >> (8 * off)) & 32'hFF;
      h = (v.rdata >> (16 * (off / 2))) & 32'hFFFF;
      case (v.f3)
        3'd0:    r.e_rdw = (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
        3'd4:    r.e_rdw = b;
        3'd1:    r.e_rdw = (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
        3'd5:    r.e_rdw = h;
        default: r.e_rdw = v.rdata;
      endcase
    end
    return r;
  endfunction

  initial begin
    vec_t        v;
    logic [31:0] rdw_m;
    logic [2:0]  legal_f3[5];
    int          kind;

    passed = 0;
    total  = 0;
    legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    //           rd wr f3    addr          wd            w  rdata         fk  fi  exc we e_addr       strb   e_wdata       e_rdw
    tbl[0]  = '{1'b1, 1'b0, 3'd2, 32'h00000100, 32'h0,        3, 32'hDEADBEEF, -1, 1'b0, 1'b0, 1'b0, 32'h00000100, 4'h0, 32'h0,        32'hDEADBEEF};
    tbl[1]  = '{1'b1, 1'b0, 3'd0, 32'h00000103, 32'h0,        0, 32'h80FF1234, -1, 1'b0, 1'b0, 1'b0, 32'h00000100, 4'h0, 32'h0,        32'hFFFFFF80};
    tbl[2]  = '{1'b1, 1'b0, 3'd4, 32'h00000103, 32'h0,        0, 32'h80FF1234, -1, 1'b0, 1'b0, 1'b0, 32'h00000100, 4'h0, 32'h0,        32'h00000080};
    tbl[3]  = '{1'b0, 1'b1, 3'd1, 32'h00000202, 32'h0000ABCD, 1, 32'h0,        -1, 1'b0, 1'b0, 1'b1, 32'h00000200, 4'hC, 32'hABCDABCD, 32'h00000080};
    tbl[4]  = '{1'b1, 1'b0, 3'd2, 32'h00000101, 32'h0,        0, 32'h0,        -1, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 32'h0,        32'h00000080};
    tbl[5]  = '{1'b1, 1'b0, 3'd1, 32'h00000300, 32'h0,        2, 32'h7FFF8000,  0, 1'b0, 1'b0, 1'b0, 32'h00000300, 4'h0, 32'h0,        32'h00000080};
    tbl[6]  = '{1'b1, 1'b0, 3'd1, 32'h00000300, 32'h0,        1, 32'h7FFF8000, -1, 1'b0, 1'b0, 1'b0, 32'h00000300, 4'h0, 32'h0,        32'hFFFF8000};
    tbl[7]  = '{1'b0, 1'b1, 3'd0, 32'h00000001, 32'h12345678, 0, 32'h0,        -1, 1'b0, 1'b0, 1'b1, 32'h00000000, 4'h2, 32'h78787878, 32'hFFFF8000};
    tbl[8]  = '{1'b1, 1'b0, 3'd5, 32'h00000102, 32'h0,        0, 32'h89AB0000, -1, 1'b0, 1'b0, 1'b0, 32'h00000100, 4'h0, 32'h0,        32'h000089AB};
    tbl[9]  = '{1'b0, 1'b1, 3'd2, 32'h00000006, 32'h0,        0, 32'h0,        -1, 1'b0, 1'b1, 1'b1, 32'h0,        4'h0, 32'h0,        32'h000089AB};
    tbl[10] = '{1'b0, 1'b1, 3'd3, 32'h00000008, 32'h0,        0, 32'h0,        -1, 1'b0, 1'b1, 1'b1, 32'h0,        4'h0, 32'h0,        32'h000089AB};
    tbl[11] = '{1'b1, 1'b0, 3'd6, 32'h00000008, 32'h0,        0, 32'h0,        -1, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 32'h0,        32'h000089AB};
    tbl[12] = '{1'b0, 1'b0, 3'd2, 32'h00000008, 32'h0,        0, 32'h0,        -1, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 32'h0,        32'h000089AB};
    tbl[13] = '{1'b1, 1'b0, 3'd2, 32'h00000010, 32'h0,        0, 32'h0,        -1, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 32'h0,        32'h000089AB};
    tbl[14] = '{1'b1, 1'b0, 3'd5, 32'h00000102, 32'h0,        3, 32'h12340000,  1, 1'b0, 1'b0, 1'b0, 32'h00000100, 4'h0, 32'h0,        32'h000089AB};

    rst_n = 1'b0;
    MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'd0;
    ALUResultM = 32'h0; WriteDataM = 32'h0; FlushM = 1'b0;
    mbus.mem_ready = 1'b0; mbus.mem_rdata = 32'h0;
    cyc();
    cyc();
    chk(mbus.mem_req == 1'b0, "reset req", {31'd0, mbus.mem_req}, 32'd0);
    chk(StallM == 1'b0, "reset stall", {31'd0, StallM}, 32'd0);
    chk(ReadDataW == 32'h0, "reset rdw", ReadDataW, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run_instr(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset while a load is waiting on memory; a late ready must be ignored.
    MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'd2; ALUResultM = 32'h40;
    mbus.mem_ready = 1'b0;
    cyc();
    chk(mbus.mem_req == 1'b1, "rst_mid busy", {31'd0, mbus.mem_req}, 32'd1);
    cyc();
    rst_n = 1'b0;
    MemReadM = 1'b0;
    cyc();
    chk(mbus.mem_req == 1'b0, "rst_mid req", {31'd0, mbus.mem_req}, 32'd0);
    chk(StallM == 1'b0, "rst_mid stall", {31'd0, StallM}, 32'd0);
    chk(ReadDataW == 32'h0, "rst_mid rdw", ReadDataW, 32'h0);
    rst_n = 1'b1;
    mbus.mem_ready = 1'b1;
    mbus.mem_rdata = 32'hCAFEF00D;
    cyc();
    mbus.mem_ready = 1'b0;
    chk(ReadDataW == 32'h0, "rst_late_ready rdw", ReadDataW, 32'h0);
    chk(mbus.mem_req == 1'b0, "rst_late_ready req", {31'd0, mbus.mem_req}, 32'd0);
    rdw_m = 32'h0;

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      v.rd = (kind <= 4);
      v.wr = (kind >= 5) && (kind <= 8);
      v.f3 = ($urandom_range(0, 4) != 0) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      v.addr = $urandom;
      if ($urandom_range(0, 1) == 0) v.addr[1:0] = 2'b00;
      v.wd = $urandom;
      v.waits = $urandom_range(0, 3);
      v.rdata = $urandom;
      v.flush_idle = ($urandom_range(0, 9) == 0);
      v.flush_k = (v.waits > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, v.waits - 1) : -1;
      v = model(v, rdw_m);
      rdw_m = v.e_rdw;
      run_instr(v, $sformatf("rnd%0d", n));
    end

    MemReadM = 1'b0;
    MemWriteM = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit for the MEM stage of the pipelined RV32I core.
- Converts EX/MEM load/store controls into a valid/ready transaction on the data-memory port.
- Stalls the pipeline until the memory responds.
- Registers the sign/zero-extended load result as ReadDataW for the writeback result mux.

Parameters:
- WIDTH, 32, data width; the design supports only 32.
- ADDR_WIDTH, 32, byte-address width.

Ports:
- clk  input  1  core clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- MemReadM  input  1  MEM-stage instruction is a load.
- MemWriteM  input  1  MEM-stage instruction is a store.
- Funct3M  input  3  access size/sign (RV32I load/store funct3).
- ALUResultM  input  ADDR_WIDTH  effective byte address.
- WriteDataM  input  WIDTH  store data (rs2).
- FlushM  input  1  kill the MEM-stage instruction.
- StallM  output  1  freeze the IF..MEM stages this cycle.
- ExcM  output  1  misaligned or illegal-funct3 access in MEM.
- ReadDataW  output  WIDTH  extended load data for the WB result mux.
- mem_req  output  1  memory request valid.
- mem_we  output  1  request is a write.
- mem_addr  output  ADDR_WIDTH  word-aligned address, with [1:0]=0.
- mem_wdata  output  WIDTH  lane-replicated store data.
- mem_wstrb  output  4  byte-lane write enables.
- mem_ready  input  1  memory completes the request this cycle.
- mem_rdata  input  WIDTH  read word, valid when mem_ready=1.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE; mem_req=0; ReadDataW=0; the discard flag clears.
  - This applies even mid-transaction: the request is dropped and mem_ready is ignored on the next cycle.
- Access defined: acc = (MemReadM|MemWriteM) & ~FlushM.
- Illegal access (bad) is any of:
  - load funct3 in {3,6,7};
  - store funct3 >= 3;
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0.
- ExcM = acc & bad & (state==IDLE), combinational. An excepting access issues no request and StallM stays 0.
- FSM states: IDLE, BUSY.
- IDLE:
  - If acc & ~bad: StallM=1, latch the request fields, go to BUSY.
  - Otherwise StallM=0.
- BUSY:
  - mem_req=1, driven from registered fields so the fields are stable until accepted.
  - StallM = ~mem_ready.
  - On mem_ready=1: go to IDLE. For a load that is not discarded, ReadDataW <= extend(mem_rdata) at that edge, so the data is valid when the instruction enters WB.
- Minimum latency is 2 cycles in MEM (memory ready in the first BUSY cycle). Each extra memory wait cycle adds one cycle.
- Back-to-back accesses: after returning to IDLE, the next instruction's access is evaluated in that same cycle. There are no bubbles beyond the one IDLE cycle.
- ReadDataW holds its value at all other times (stores, non-memory instructions, excepting accesses).
- FlushM in BUSY:
  - The transaction cannot be aborted, so mem_req stays asserted until ready.
  - The discard flag is set, and the load result is not written at completion.
  - A store already issued commits.
  - The discard flag clears on return to IDLE.
- Store formatting, by access size:
  - Byte: wstrb = 4'b0001 << addr[1:0]; wdata = {4{byte}}.
  - Half: wstrb = 4'b0011 << {addr[1],1'b0}; wdata = {2{half}}.
  - Word: wstrb = 4'hF; wdata unchanged.
  - Loads drive wstrb=0 and mem_we=0.
- Load extract uses the latched addr[1:0]:
  - lb/lbu: select byte addr[1:0]; lb sign-extends, lbu zero-extends.
  - lh/lhu: select half addr[1]; lh sign-extends, lhu zero-extends.
  - lw: pass the word through.

Decomposition:
- Package lsu_pkg contains:
  - funct3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5;
  - state enum lsu_state_t {IDLE, BUSY}.
- Sub-module load_extend: combinational; inputs funct3, addr[1:0], rdata; output the extended word. It is reused for ReadDataW.

Test Plan:
- Word load:
  - Stimulus: lw at 0x100, memory ready after 3 wait cycles with rdata=0xDEADBEEF.
  - Response: mem_addr=0x100, mem_req held for 4 cycles; StallM=1 for 4 cycles then 0; ReadDataW=0xDEADBEEF on the following cycle.
- Byte loads:
  - Stimulus: lb at 0x103 with rdata=0x80FF1234, then lbu at the same address.
  - Response: ReadDataW=0xFFFFFF80, then 0x00000080.
- Store formatting:
  - Stimulus: sh at 0x202 with WriteDataM=0x0000ABCD.
  - Response: mem_we=1, mem_addr=0x200, mem_wstrb=4'b1100, mem_wdata=0xABCDABCD; ReadDataW unchanged.
- Misaligned access:
  - Stimulus: lw at 0x101.
  - Response: ExcM=1, mem_req=0, StallM=0.
- Flush in BUSY:
  - Stimulus: FlushM pulsed during BUSY of lh 0x300 with rdata=0x7FFF8000.
  - Response: handshake completes; ReadDataW keeps its old value.
  - Follow-up: an unflushed lh 0x300 afterwards gives ReadDataW=0xFFFF8000.
- Reset mid-transaction:
  - Stimulus: rst_n=0 mid-BUSY.
  - Response: next cycle mem_req=0, StallM=0, ReadDataW=0; a mem_ready arriving after reset has no effect.
